// File: rtl/serial_proto_pkg.sv
// serial_proto_pkg: FSM states, opcodes and response sizes for the serial command protocol
package serial_proto_pkg;
  typedef enum logic [2:0] {IDLE, TX_OP, TX_OP_GAP, TX_ARG, TX_ARG_GAP, RECV, FINISH} state_t;
  localparam logic [7:0] OP_VERSION       = 8'd0;
  localparam logic [7:0] OP_SET_DEAD      = 8'd1;
  localparam logic [7:0] OP_SET_FIRE      = 8'd2;
  localparam logic [7:0] OP_TOGGLE_OUT    = 8'd3;
  localparam logic [7:0] OP_TOGGLE_CLKSRC = 8'd4;
  localparam logic [7:0] OP_SET_PHASE     = 8'd5;
  localparam logic [7:0] OP_SET_MASK1     = 8'd6;
  localparam logic [7:0] OP_SET_MASK2     = 8'd7;
  localparam logic [7:0] OP_PASSTHRU      = 8'd8;
  localparam logic [7:0] OP_READ_HIST     = 8'd10;
  localparam logic [7:0] OP_TOGGLE_VETO   = 8'd11;
  localparam logic [7:0] OP_RESET_PLL     = 8'd13;
  localparam logic [7:0] OP_SET_VETO_CYC  = 8'd14;
  localparam logic [7:0] OP_CLK_AS_INPUT  = 8'd15;
  localparam int HIST_RESP_BYTES = 128;
endpackage

// File: rtl/resp_word_packer.sv
// resp_word_packer: packs response bytes little-endian into 32-bit words, flushing a zero-padded partial word on the last byte
module resp_word_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [1:0]  i_lane,
  input  logic        i_last,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word_data,
  output logic [6:0]  o_word_index
);
  logic [31:0] r_acc;
  logic [6:0]  r_idx;
  logic [31:0] w_acc;
  logic        w_flush;

  assign w_acc   = r_acc | (32'(i_byte) << {i_lane, 3'b000});
  assign w_flush = i_valid && (i_lane == 2'd3 || i_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc        <= '0;
      r_idx        <= '0;
      o_word_valid <= 1'b0;
      o_word_data  <= '0;
      o_word_index <= '0;
    end else begin
      o_word_valid <= w_flush;
      if (w_flush) begin
        o_word_data  <= w_acc;
        o_word_index <= r_idx;
      end
      r_acc <= (i_clear || w_flush) ? '0 : i_valid ? w_acc : r_acc;
      r_idx <= i_clear ? '0 : w_flush ? r_idx + 7'd1 : r_idx;
    end
  end
endmodule

// File: rtl/serial_cmd_initiator.sv
// serial_cmd_initiator: sends an opcode and optional argument byte over UART,
// then collects the response and emits it as little-endian 32-bit words
module serial_cmd_initiator
  import serial_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int MAX_RESP_BYTES = 288
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [7:0]  cmd_arg,
  input  logic        cmd_has_arg,
  input  logic [8:0]  cmd_resp_len,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        rxReady,
  input  logic [7:0]  rxData,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [6:0]  word_index,
  output logic        done,
  output logic        timeout,
  output logic        busy
);
  localparam logic [22:0] TO_LAST = 23'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]  LEN_MAX = 9'(MAX_RESP_BYTES);

  state_t      r_state, w_next, w_post;
  logic [7:0]  r_opcode, r_arg, w_tx_data;
  logic        r_has_arg;
  logic [8:0]  r_resp_len, r_byte_cnt;
  logic [22:0] r_to_cnt;
  logic        w_accept, w_rx, w_last, w_expire, w_tx_start, w_done;

  assign w_accept = r_state == IDLE && cmd_valid && cmd_ready;
  assign w_rx     = r_state == RECV && rxReady;
  assign w_last   = w_rx && r_byte_cnt == r_resp_len - 9'd1;
  // a byte arriving on the expiry cycle wins over the timeout
  assign w_expire = r_state == RECV && !rxReady && r_to_cnt == TO_LAST;
  assign w_post   = r_resp_len != '0 ? RECV : FINISH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = w_accept ? TX_OP : IDLE;
      TX_OP:      w_next = txBusy ? TX_OP : TX_OP_GAP;
      TX_OP_GAP:  w_next = r_has_arg ? TX_ARG : w_post;
      TX_ARG:     w_next = txBusy ? TX_ARG : TX_ARG_GAP;
      TX_ARG_GAP: w_next = w_post;
      RECV:       w_next = w_last ? FINISH : w_expire ? IDLE : RECV;
      FINISH:     w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    w_tx_start = (r_state == TX_OP || r_state == TX_ARG) && !txBusy;
    w_tx_data  = r_state == TX_ARG ? r_arg : r_opcode;
    w_done     = r_state == FINISH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      txStart    <= 1'b0;
      txData     <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      r_opcode   <= '0;
      r_arg      <= '0;
      r_has_arg  <= 1'b0;
      r_resp_len <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      cmd_ready <= w_next == IDLE;
      busy      <= w_next != IDLE;
      txStart   <= w_tx_start;
      if (w_tx_start) txData <= w_tx_data;
      done      <= w_done;
      timeout   <= w_expire;
      if (w_accept) begin
        r_opcode   <= cmd_opcode;
        r_arg      <= cmd_arg;
        r_has_arg  <= cmd_has_arg;
        r_resp_len <= cmd_resp_len > LEN_MAX ? LEN_MAX : cmd_resp_len;
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
      end else if (w_rx) begin
        r_byte_cnt <= r_byte_cnt + 9'd1;
        r_to_cnt   <= '0;
      end else if (r_state == RECV && r_to_cnt != '1) begin
        r_to_cnt <= r_to_cnt + 23'd1;
      end
    end
  end

  resp_word_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_accept || w_expire),
    .i_valid      (w_rx),
    .i_lane       (r_byte_cnt[1:0]),
    .i_last       (w_last),
    .i_byte       (rxData),
    .o_word_valid (word_valid),
    .o_word_data  (word_data),
    .o_word_index (word_index)
  );
endmodule

// File: tb/tb_serial_cmd_initiator.sv
// tb_serial_cmd_initiator: timeline model of expected tx bytes, words, done and timeout events, checked every cycle
module tb_serial_cmd_initiator;
  localparam int T = 100;
  localparam int K = 2;

  logic        clk = 0, reset_n = 0;
  logic        cmd_valid = 0, cmd_has_arg = 0, txBusy = 0, rxReady = 0;
  logic [7:0]  cmd_opcode = 0, cmd_arg = 0, rxData = 0;
  logic [8:0]  cmd_resp_len = 0;
  logic        cmd_ready, txStart, word_valid, done, timeout, busy;
  logic [7:0]  txData;
  logic [31:0] word_data;
  logic [6:0]  word_index;

  serial_cmd_initiator #(.TIMEOUT_CYCLES(T), .MAX_RESP_BYTES(288)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg), .cmd_has_arg(cmd_has_arg),
    .cmd_resp_len(cmd_resp_len), .txBusy(txBusy), .txStart(txStart), .txData(txData),
    .rxReady(rxReady), .rxData(rxData), .word_valid(word_valid), .word_data(word_data),
    .word_index(word_index), .done(done), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit run = 0;
  int fb_lo = 0, fb_hi = -1, blo = 0, bhi = -1;
  int last_start = -1000, first_start = -1;
  int t_a, t_g, t_end;
  int nwords, ndone, nto;
  logic [25:0] cv_at[int];
  logic [7:0]  rx_at[int];
  logic [7:0]  exp_tx[int];
  logic [38:0] exp_word[int];
  bit          exp_done[int];
  bit          exp_to[int];
  logic [31:0] words_seen[int];
  logic [7:0]  tx_log[$];
  bit          bexp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit in_fb(input int c);
    return c >= fb_lo && c <= fb_hi;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // stimulus driver: command/rx schedule plus a transmitter that stays busy K cycles after each start
  always @(posedge clk) begin
    #1;
    txBusy  = in_fb(cyc) || (cyc > last_start && cyc <= last_start + K);
    rxReady = rx_at.exists(cyc);
    rxData  = rxReady ? rx_at[cyc] : 8'h00;
    cmd_valid = cv_at.exists(cyc);
    {cmd_opcode, cmd_arg, cmd_has_arg, cmd_resp_len} = cmd_valid ? cv_at[cyc] : 26'd0;
  end

  always @(negedge clk) begin
    if (run) begin
      bexp = cyc >= blo && cyc <= bhi;
      chk("busy", busy, bexp);
      chk("cmd_ready", cmd_ready, !bexp);
      chk("txStart", txStart, exp_tx.exists(cyc));
      if (txStart && exp_tx.exists(cyc)) chk("txData", txData, exp_tx[cyc]);
      chk("word_valid", word_valid, exp_word.exists(cyc));
      if (word_valid && exp_word.exists(cyc)) chk("word", {word_index, word_data}, exp_word[cyc]);
      chk("done", done, exp_done.exists(cyc));
      chk("timeout", timeout, exp_to.exists(cyc));
      if (txStart) begin
        last_start = cyc;
        tx_log.push_back(txData);
        if (first_start < 0) first_start = cyc;
      end
      if (word_valid) begin
        words_seen[int'(word_index)] = word_data;
        nwords++;
      end
      if (done) ndone++;
      if (timeout) nto++;
    end
  end

  task automatic plan(input logic [7:0] op, input logic [7:0] arg, input logic ha,
                      input int len_req, input int nsend, input int sp, input int gap1,
                      input int bcnt, input logic [7:0] base, input logic [7:0] step);
    int s, r, lr, lenc;
    logic [31:0] w;
    logic [7:0] b;
    nwords = 0; ndone = 0; nto = 0; first_start = -1;
    tx_log.delete(); words_seen.delete();
    t_a = cyc + 2;
    cv_at[t_a] = {op, arg, ha, 9'(len_req)};
    cv_at[t_a + 2] = {8'hEE, 8'hEE, 1'b1, 9'd5};
    rx_at[t_a + 1] = 8'hAA;
    fb_lo = t_a + 1; fb_hi = t_a + bcnt;
    lenc = len_req > 288 ? 288 : len_req;
    s = t_a + 1;
    while (in_fb(s)) s++;
    exp_tx[s + 1] = op; t_g = s + 1;
    if (ha) begin
      s = t_g + 1;
      while (in_fb(s) || s <= t_g + K) s++;
      exp_tx[s + 1] = arg; t_g = s + 1;
    end
    lr = t_g; r = t_g + 1; w = '0;
    for (int i = 0; i < nsend; i++) begin
      b = base + 8'(i) * step;
      rx_at[r] = b;
      w = w | (32'(b) << (8 * (i % 4)));
      if (i % 4 == 3 || i == lenc - 1) begin
        exp_word[r + 1] = {7'(i / 4), w};
        w = '0;
      end
      lr = r;
      r = r + ((i == 0 && gap1 > 0) ? gap1 : sp);
    end
    if (nsend == lenc) begin
      t_end = lr + 2;
      exp_done[t_end] = 1;
    end else begin
      t_end = (nsend > 0 ? lr + 1 : t_g + 1) + T;
      exp_to[t_end] = 1;
    end
    rx_at[t_end] = 8'h55;
    blo = t_a + 1; bhi = t_end - 1;
  endtask

  task automatic finish_txn();
    while (cyc < t_end + 2) @(posedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_txStart"}, txStart, 0);
    chk({tag, "_txData"}, txData, 0);
    chk({tag, "_word_valid"}, word_valid, 0);
    chk({tag, "_word_data"}, word_data, 0);
    chk({tag, "_word_index"}, word_index, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    reset_n = 1;
    @(negedge clk);
    run = 1;
    // version read
    plan(8'd0, 8'd0, 0, 1, 1, 1, 0, 0, 8'h17, 8'h00);
    finish_txn();
    chk("ver_word", words_seen[0], 32'h0000_0017);
    chk("ver_tx", tx_log[0], 8'h00);
    chk("ver_done", ndone, 1);
    // setter with arg, zero-length response
    plan(8'd1, 8'h0A, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    finish_txn();
    chk("set_ntx", tx_log.size(), 2);
    chk("set_tx1", tx_log[1], 8'h0A);
    chk("set_nwords", nwords, 0);
    chk("set_done", ndone, 1);
    // histogram read
    plan(8'd10, 8'd0, 0, 128, 128, 1, 0, 0, 8'h00, 8'h01);
    finish_txn();
    chk("hist_nwords", nwords, 32);
    chk("hist_w0", words_seen[0], 32'h0302_0100);
    chk("hist_w31", words_seen[31], 32'h7F7E_7D7C);
    // partial final word
    plan(8'd5, 8'h33, 1, 6, 6, 3, 0, 0, 8'h00, 8'h01);
    finish_txn();
    chk("part_nwords", nwords, 2);
    chk("part_w1", words_seen[1], 32'h0000_0504);
    // timeout with 2 of 4 bytes
    plan(8'd8, 8'd0, 0, 4, 2, 2, 0, 0, 8'h10, 8'h01);
    finish_txn();
    chk("to_nwords", nwords, 0);
    chk("to_count", nto, 1);
    chk("to_done", ndone, 0);
    chk("to_idle", cmd_ready, 1);
    // txBusy held high for 50 cycles
    plan(8'd11, 8'd0, 0, 0, 0, 1, 0, 50, 8'h00, 8'h00);
    finish_txn();
    chk("busy50_start", first_start - t_a, 52);
    // byte arriving exactly on the expiry cycle wins
    plan(8'd2, 8'd0, 0, 3, 3, 1, T, 0, 8'h40, 8'h01);
    finish_txn();
    chk("win_to", nto, 0);
    chk("win_done", ndone, 1);
    chk("win_w0", words_seen[0], 32'h0042_4140);
    // over-long request clamps to 288 bytes
    plan(8'd10, 8'd0, 0, 300, 288, 1, 0, 0, 8'h00, 8'h01);
    finish_txn();
    chk("clamp_nwords", nwords, 72);
    chk("clamp_w71", words_seen[71], 32'h1F1E_1D1C);
    chk("clamp_done", ndone, 1);
    // reset during RECV
    plan(8'd10, 8'd0, 0, 8, 8, 2, 0, 0, 8'h20, 8'h01);
    while (cyc < t_g + 4) @(posedge clk);
    @(negedge clk);
    run = 0;
    reset_n = 0;
    #1;
    check_reset("midrst");
    exp_tx.delete(); exp_word.delete(); exp_done.delete(); exp_to.delete();
    rx_at.delete(); cv_at.delete();
    blo = 0; bhi = -1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    run = 1;
    plan(8'd0, 8'd0, 0, 1, 1, 1, 0, 0, 8'h99, 8'h00);
    finish_txn();
    chk("post_rst_word", words_seen[0], 32'h0000_0099);
    chk("post_rst_done", ndone, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
